// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - decode stage: instruction decode, 16x16 register file, load-use stall, decode/execute pipeline register
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [15:0] instr,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [3:0]  wb_rd,
    input  logic [15:0] wb_data,
    output logic [15:0] pcout,
    output logic [15:0] aout,
    output logic [15:0] bout,
    output logic [3:0]  rdout,
    output logic [15:0] immout,
    output logic        aluop,
    output logic        aluin1,
    output logic [1:0]  aluin2,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        branch,
    output logic        jump,
    output logic        stall
);

    logic [15:0] regs [16];

    logic [3:0]  op, rd, rs1, rs2, b_idx;
    logic [15:0] imm4, imm8, a_val, b_val;

    assign op    = instr[15:12];
    assign rd    = instr[11:8];
    assign rs1   = instr[7:4];
    assign rs2   = instr[3:0];
    assign b_idx = (op == 4'h4 || op == 4'h5) ? rd : rs2;
    assign imm4  = {{12{instr[3]}}, instr[3:0]};
    assign imm8  = {{8{instr[7]}}, instr[7:0]};

    // Write-through: a same-cycle writeback to the read index wins over the stored value.
    always_comb begin
        a_val = regs[rs1];
        if (rs1 == 4'd0)
            a_val = 16'd0;
        else if (wb_en && wb_rd == rs1)
            a_val = wb_data;
        b_val = regs[b_idx];
        if (b_idx == 4'd0)
            b_val = 16'd0;
        else if (wb_en && wb_rd == b_idx)
            b_val = wb_data;
    end

    logic        d_valid, d_aluop, d_aluin1, d_memread, d_memwrite;
    logic        d_regwrite, d_memtoreg, d_branch, d_jump, use_rs1, use_b;
    logic [1:0]  d_aluin2;
    logic [3:0]  d_rd;
    logic [15:0] d_imm;

    always_comb begin
        d_valid    = 1'b0;
        d_aluop    = 1'b0;
        d_aluin1   = 1'b0;
        d_aluin2   = 2'd0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_branch   = 1'b0;
        d_jump     = 1'b0;
        d_rd       = 4'd0;
        d_imm      = 16'd0;
        use_rs1    = 1'b0;
        use_b      = 1'b0;
        case (op)
            4'h0, 4'h1: begin
                d_valid    = 1'b1;
                d_aluin1   = 1'b1;
                d_aluop    = op[0];
                d_regwrite = 1'b1;
                d_rd       = rd;
                use_rs1    = 1'b1;
                use_b      = 1'b1;
            end
            4'h2, 4'h3: begin
                d_valid    = 1'b1;
                d_aluin1   = 1'b1;
                d_aluin2   = 2'd2;
                d_regwrite = 1'b1;
                d_memread  = op[0];
                d_memtoreg = op[0];
                d_rd       = rd;
                d_imm      = imm4;
                use_rs1    = 1'b1;
            end
            4'h4: begin
                d_valid    = 1'b1;
                d_aluin1   = 1'b1;
                d_aluin2   = 2'd2;
                d_memwrite = 1'b1;
                d_imm      = imm4;
                use_rs1    = 1'b1;
                use_b      = 1'b1;
            end
            4'h5: begin
                d_valid    = 1'b1;
                d_aluin1   = 1'b1;
                d_aluop    = 1'b1;
                d_branch   = 1'b1;
                d_imm      = imm4;
                use_rs1    = 1'b1;
                use_b      = 1'b1;
            end
            4'h6: begin
                d_valid    = 1'b1;
                d_aluin2   = 2'd1;
                d_regwrite = 1'b1;
                d_jump     = 1'b1;
                d_rd       = rd;
                d_imm      = imm8;
            end
            default: ;
        endcase
    end

    // Load-use: the load now in execute targets a source this instruction actually reads.
    assign stall = memread && (rdout != 4'd0) && !flush && !rst &&
                   ((use_rs1 && rdout == rs1) || (use_b && rdout == b_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= 16'd0;
        end else if (wb_en && wb_rd != 4'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || stall || !d_valid) begin
            pcout    <= 16'd0;
            aout     <= 16'd0;
            bout     <= 16'd0;
            rdout    <= 4'd0;
            immout   <= 16'd0;
            aluop    <= 1'b0;
            aluin1   <= 1'b0;
            aluin2   <= 2'd0;
            memread  <= 1'b0;
            memwrite <= 1'b0;
            regwrite <= 1'b0;
            memtoreg <= 1'b0;
            branch   <= 1'b0;
            jump     <= 1'b0;
        end else begin
            pcout    <= pc;
            aout     <= a_val;
            bout     <= b_val;
            rdout    <= d_rd;
            immout   <= d_imm;
            aluop    <= d_aluop;
            aluin1   <= d_aluin1;
            aluin2   <= d_aluin2;
            memread  <= d_memread;
            memwrite <= d_memwrite;
            regwrite <= d_regwrite;
            memtoreg <= d_memtoreg;
            branch   <= d_branch;
            jump     <= d_jump;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - directed and randomized checks of decode_cycle against a table-driven reference model
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst, flush, wb_en;
    logic [15:0] pc, instr, wb_data;
    logic [3:0]  wb_rd;
    logic [15:0] pcout, aout, bout, immout;
    logic [3:0]  rdout;
    logic        aluop, aluin1, memread, memwrite, regwrite, memtoreg, branch, jump, stall;
    logic [1:0]  aluin2;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .pcout(pcout), .aout(aout), .bout(bout), .rdout(rdout), .immout(immout),
        .aluop(aluop), .aluin1(aluin1), .aluin2(aluin2),
        .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
        .memtoreg(memtoreg), .branch(branch), .jump(jump), .stall(stall)
    );

    typedef struct packed {
        logic [15:0] pc, a, b, imm;
        logic [3:0]  rd;
        logic [9:0]  ctrl;
    } pipe_t;

    // {aluop, aluin1, aluin2[1:0], memread, memwrite, regwrite, memtoreg, branch, jump}
    logic [9:0] ctrl_tbl [7] = '{10'b0_1_00_0_0_1_0_0_0, 10'b1_1_00_0_0_1_0_0_0,
                                 10'b0_1_10_0_0_1_0_0_0, 10'b0_1_10_1_0_1_1_0_0,
                                 10'b0_1_10_0_1_0_0_0_0, 10'b1_1_00_0_0_0_0_1_0,
                                 10'b0_0_01_0_0_1_0_0_1};
    int imm_kind [7] = '{0, 0, 4, 4, 4, 4, 8};

    logic [15:0] mregs [16];
    pipe_t       cur;
    logic        last_stall;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_ref(input logic [3:0] idx);
        if (idx == 0) return 16'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    function automatic logic [3:0] b_sel(input logic [15:0] ins);
        return (ins[15:12] == 4 || ins[15:12] == 5) ? ins[11:8] : ins[3:0];
    endfunction

    function automatic pipe_t decode_ref(input logic [15:0] ins, input logic [15:0] p);
        pipe_t r = '0;
        int o = int'(ins[15:12]);
        if (o > 6) return r;
        r.ctrl = ctrl_tbl[o];
        r.pc   = p;
        r.a    = rd_ref(ins[7:4]);
        r.b    = rd_ref(b_sel(ins));
        r.rd   = r.ctrl[3] ? ins[11:8] : 4'd0;
        if (imm_kind[o] == 4) r.imm = 16'($signed(ins[3:0]));
        if (imm_kind[o] == 8) r.imm = 16'($signed(ins[7:0]));
        return r;
    endfunction

    function automatic logic reads_reg(input logic [15:0] ins, input logic [3:0] r);
        int o = int'(ins[15:12]);
        if (o > 5) return 1'b0;
        if (ins[7:4] == r) return 1'b1;
        return (o == 0 || o == 1 || o == 4 || o == 5) && b_sel(ins) == r;
    endfunction

    task automatic check_outputs();
        chk("pcout", pcout, cur.pc);
        chk("aout", aout, cur.a);
        chk("bout", bout, cur.b);
        chk("immout", immout, cur.imm);
        chk("rdout", {12'd0, rdout}, {12'd0, cur.rd});
        chk("ctrl", {6'd0, aluop, aluin1, aluin2, memread, memwrite, regwrite, memtoreg, branch, jump},
            {6'd0, cur.ctrl});
    endtask

    task automatic step(input logic [15:0] i_instr, input logic [15:0] i_pc, input logic i_flush,
                        input logic i_wen, input logic [3:0] i_wrd, input logic [15:0] i_wdata,
                        input logic i_rst);
        logic  exp_stall;
        pipe_t nxt;
        instr = i_instr; pc = i_pc; flush = i_flush; rst = i_rst;
        wb_en = i_wen; wb_rd = i_wrd; wb_data = i_wdata;
        #1;
        exp_stall = !i_rst && !i_flush && cur.ctrl[5] && cur.rd != 0 && reads_reg(i_instr, cur.rd);
        chk("stall", {15'd0, stall}, {15'd0, exp_stall});
        nxt = (i_rst || i_flush || exp_stall) ? '0 : decode_ref(i_instr, i_pc);
        @(posedge clk);
        if (i_rst) begin
            for (int i = 0; i < 16; i++) mregs[i] = 16'd0;
        end else if (i_wen && i_wrd != 0) begin
            mregs[i_wrd] = i_wdata;
        end
        cur = nxt;
        last_stall = exp_stall;
        #1;
        check_outputs();
    endtask

    initial begin
        logic [15:0] ri, rp;
        cur = '0;
        last_stall = 1'b0;
        for (int i = 0; i < 16; i++) mregs[i] = 16'hDEAD;
        rst = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_rd = 4'd0; wb_data = 16'd0;
        pc = 16'd0; instr = 16'd0;

        step(16'h0123, 16'h0002, 1'b0, 1'b1, 4'd1, 16'hBEEF, 1'b1);
        chk("reset_regwrite", {15'd0, regwrite}, 16'd0);
        for (int i = 1; i < 16; i++)
            step({4'h0, 4'(i), 4'(i), 4'(i)}, 16'(2 * i), 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);

        step(16'h0530, 16'h0040, 1'b0, 1'b1, 4'd3, 16'h1234, 1'b0);
        chk("bypass_a", aout, 16'h1234);
        chk("bypass_rd", {12'd0, rdout}, 16'd5);

        step(16'h321F, 16'h0042, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        chk("lw_imm", immout, 16'hFFFF);
        chk("lw_memread", {15'd0, memread}, 16'd1);
        step(16'h0422, 16'h0044, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        chk("lu_stall", {15'd0, last_stall}, 16'd1);
        step(16'h0422, 16'h0044, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        chk("lu_issue_rd", {12'd0, rdout}, 16'd4);

        step(16'h6704, 16'h0010, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        chk("jal_imm", immout, 16'h0004);
        chk("jal_jump", {15'd0, jump}, 16'd1);

        step(16'h321F, 16'h0046, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        step(16'h0422, 16'h0048, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
        chk("flush_wins", {15'd0, last_stall}, 16'd0);

        step(16'h0000, 16'h004A, 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
        step(16'h0100, 16'h004C, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        chk("r0_zero", aout, 16'd0);
        step(16'hA123, 16'h004E, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);

        ri = 16'h0;
        rp = 16'h0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                ri[15:12] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
                ri[11:0]  = ($urandom_range(0, 1) == 0) ? 12'($urandom) :
                            {2'b0, 2'($urandom), 2'b0, 2'($urandom), 2'b0, 2'($urandom)};
                rp = 16'($urandom);
            end
            step(ri, rp, $urandom_range(0, 9) == 0, 1'($urandom), 4'($urandom_range(0, 3)),
                 16'($urandom), $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
